// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int WORD_LEN = 32;

    typedef enum logic {
        MS_IDLE,
        MS_ACCESS
    } memstate_t;

    // Word accesses only: both low address bits must be clear.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/ack bus between the memory stage and data memory.
// Latency: n/a (signal bundle).
// Backpressure: request held until a one-cycle ack or stage-side abort.
interface mem_stage_if import mem_stage_pkg::*; ;

    logic                mem_req;
    logic                mem_we;
    logic [WORD_LEN-1:0] mem_addr;
    logic [WORD_LEN-1:0] mem_wdata;
    logic                mem_ack;
    logic [WORD_LEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register with explicit load and bubble controls.
// Latency: 1 cycle from load to outputs.
// Backpressure: none; holds its contents when neither load nor bubble is asserted.
module mem_wb_reg import mem_stage_pkg::*; #(
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    bubble,
    input  logic                    wb_en_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic [WORD_LEN-1:0]     result_in,
    output logic                    WB_EN_out,
    output logic [REG_ADDR_LEN-1:0] dest_out,
    output logic [WORD_LEN-1:0]     result_out
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            WB_EN_out  <= 1'b0;
            dest_out   <= '0;
            result_out <= '0;
        end else if (load) begin
            WB_EN_out  <= wb_en_in;
            dest_out   <= dest_in;
            result_out <= result_in;
        end else if (bubble) begin
            // Only the write enable matters downstream; dest/result keep last value.
            WB_EN_out  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues req/ack data-memory accesses and owns the MEM/WB register.
// Latency: 1 cycle for non-memory ops; memory ops take 1 + ack wait cycles (min 2).
// Backpressure: stall held while an access is outstanding; aborts after TIMEOUT access cycles.
module mem_stage import mem_stage_pkg::*; #(
    parameter int REG_ADDR_LEN = 5,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic                    MEM_R_EN,
    input  logic                    MEM_W_EN,
    input  logic                    WB_EN,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic [WORD_LEN-1:0]     ALU_res,
    input  logic [WORD_LEN-1:0]     ST_value,
    output logic [WORD_LEN-1:0]     ALU_res_MEM,
    output logic                    stall,
    mem_stage_if.master             mem,
    output logic                    WB_EN_out,
    output logic [REG_ADDR_LEN-1:0] dest_out,
    output logic [WORD_LEN-1:0]     result_out,
    output logic                    misalign_err,
    output logic                    timeout_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    memstate_t               state;
    logic [CNT_W-1:0]        count;
    logic [REG_ADDR_LEN-1:0] lat_dest;
    logic                    lat_wb_en;

    logic                    memop;
    logic                    aligned;
    logic                    last;
    logic                    wb_load;
    logic                    wb_bubble;
    logic                    wb_en_nxt;
    logic [REG_ADDR_LEN-1:0] dest_nxt;
    logic [WORD_LEN-1:0]     res_nxt;

    assign ALU_res_MEM = ALU_res;

    always_comb begin
        memop     = valid_in & (MEM_R_EN | MEM_W_EN);
        aligned   = is_aligned(ALU_res[1:0]);
        last      = (count == CNT_LAST);
        stall     = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_en_nxt = WB_EN;
        dest_nxt  = dest_in;
        res_nxt   = ALU_res;
        case (state)
            MS_IDLE: begin
                if (memop) begin
                    stall     = aligned;
                    wb_bubble = 1'b1;
                end else if (valid_in) begin
                    wb_load   = 1'b1;
                end else begin
                    wb_bubble = 1'b1;
                end
            end
            MS_ACCESS: begin
                stall = ~mem.mem_ack & ~last;
                if (mem.mem_ack) begin
                    // Stores complete without a register write; their result is the address.
                    wb_load   = 1'b1;
                    wb_en_nxt = lat_wb_en & ~mem.mem_we;
                    dest_nxt  = lat_dest;
                    res_nxt   = mem.mem_we ? mem.mem_addr : mem.mem_rdata;
                end else begin
                    wb_bubble = 1'b1;
                end
            end
            default: wb_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= MS_IDLE;
            count         <= '0;
            lat_dest      <= '0;
            lat_wb_en     <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            misalign_err  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                MS_IDLE: begin
                    if (memop && aligned) begin
                        state         <= MS_ACCESS;
                        count         <= '0;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= MEM_W_EN;
                        mem.mem_addr  <= ALU_res;
                        mem.mem_wdata <= ST_value;
                        lat_dest      <= dest_in;
                        lat_wb_en     <= WB_EN;
                    end else if (memop) begin
                        misalign_err  <= 1'b1;
                    end
                end
                MS_ACCESS: begin
                    // An ack in the final allowed cycle still completes the access.
                    if (mem.mem_ack) begin
                        state       <= MS_IDLE;
                        count       <= '0;
                        mem.mem_req <= 1'b0;
                    end else if (last) begin
                        state       <= MS_IDLE;
                        count       <= '0;
                        mem.mem_req <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        count       <= count + 1'b1;
                    end
                end
                default: begin
                    state       <= MS_IDLE;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end

    mem_wb_reg #(
        .REG_ADDR_LEN (REG_ADDR_LEN)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (wb_load),
        .bubble     (wb_bubble),
        .wb_en_in   (wb_en_nxt),
        .dest_in    (dest_nxt),
        .result_in  (res_nxt),
        .WB_EN_out  (WB_EN_out),
        .dest_out   (dest_out),
        .result_out (result_out)
    );

endmodule
